// File: rtl/nvram_upload.sv
// nvram_upload: streams a window of game work RAM back to the HPS during an ioctl upload.
// Optional NVRAM_UPLOAD_CHECKSUM_EN appends a 16-bit byte sum at addresses SIZE and SIZE+1.
module nvram_upload #(
  parameter int ADDR_W       = 10,
  parameter int BASE         = 0,
  parameter int SIZE         = 256,
  parameter int RAM_LAT      = 1,
  parameter int UPLOAD_INDEX = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              pause_req,
  input  logic              pause_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_dout,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAUSE,
    S_READY,
    S_FETCH,
    S_PRESENT,
    S_RELEASE
  } state_t;

  localparam logic [24:0]       SIZE_A  = 25'(SIZE);
  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE);
  localparam logic [1:0]        LAT_C   = 2'(RAM_LAT);
  localparam logic [7:0]        INDEX_C = 8'(UPLOAD_INDEX);

  state_t     state;
  logic [1:0] lat_cnt;
  logic       active;
  logic       in_range;
  logic       fetch_done;
  logic [7:0] oor_byte;

  assign active     = ioctl_upload && (ioctl_index == INDEX_C);
  assign in_range   = ioctl_addr < SIZE_A;
  assign fetch_done = (state == S_FETCH) && active && (lat_cnt == LAT_C);

`ifdef NVRAM_UPLOAD_CHECKSUM_EN
  logic [15:0] sum;

  // Sum restarts with each session and only counts bytes actually handed to the HPS.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sum <= 16'h0000;
    end else if ((state == S_IDLE) && active) begin
      sum <= 16'h0000;
    end else if (fetch_done) begin
      sum <= sum + {8'h00, ram_dout};
    end
  end

  always_comb begin
    oor_byte = 8'h00;
    if (ioctl_addr == SIZE_A) begin
      oor_byte = sum[7:0];
    end else if (ioctl_addr == SIZE_A + 25'd1) begin
      oor_byte = sum[15:8];
    end
  end
`else
  assign oor_byte = 8'h00;
`endif

  // Losing the session wins over everything else, so an in-flight fetch is simply dropped.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= S_IDLE;
      lat_cnt    <= 2'd0;
      ioctl_din  <= 8'h00;
      ioctl_wait <= 1'b0;
      pause_req  <= 1'b0;
      ram_addr   <= '0;
      ram_rd     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      ram_rd <= 1'b0;
      if (state != S_IDLE && state != S_RELEASE && !active) begin
        state      <= S_RELEASE;
        pause_req  <= 1'b0;
        ioctl_wait <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (active) begin
              state      <= S_PAUSE;
              pause_req  <= 1'b1;
              ioctl_wait <= 1'b1;
              busy       <= 1'b1;
            end
          end
          S_PAUSE: begin
            if (pause_ack) begin
              state      <= S_READY;
              ioctl_wait <= 1'b0;
            end
          end
          S_READY: begin
            if (ioctl_rd) begin
              if (in_range) begin
                ram_addr   <= BASE_A + ioctl_addr[ADDR_W-1:0];
                ram_rd     <= 1'b1;
                ioctl_wait <= 1'b1;
                lat_cnt    <= 2'd0;
                state      <= S_FETCH;
              end else begin
                ioctl_din <= oor_byte;
              end
            end
          end
          S_FETCH: begin
            if (lat_cnt == LAT_C) begin
              ioctl_din  <= ram_dout;
              ioctl_wait <= 1'b0;
              state      <= S_PRESENT;
            end else begin
              lat_cnt <= lat_cnt + 2'd1;
            end
          end
          S_PRESENT: state <= S_READY;
          S_RELEASE: state <= S_IDLE;
          default:   state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/nvram_upload.md
Name: nvram_upload

Overview:
- Serves HPS upload requests (ioctl_upload) by streaming a window of game work RAM (high-score / NVRAM area) back to the HPS, byte by byte.
- This is the reverse of the ioctl download path that loads ROMs and DIP bytes.
- Sits beside hps_io in the emu top:
  - pauses the game CPU;
  - reads RAM through a shared read port;
  - returns bytes on ioctl_din, using ioctl_wait as backpressure.

Parameters:
- ADDR_W, 10: width of RAM byte address.
- BASE, 0: RAM offset of the first uploaded byte.
- SIZE, 256: number of RAM bytes uploaded (1..2^ADDR_W).
- RAM_LAT, 1: RAM read latency in cycles (1..3).
- UPLOAD_INDEX, 4: ioctl_index value that selects this block.

Ports:
- clk_sys in 1: system clock, 40 MHz.
- reset in 1: synchronous, active-high.
- ioctl_upload in 1: HPS upload session active.
- ioctl_index in 8: session file index.
- ioctl_rd in 1: one-cycle read strobe for ioctl_addr.
- ioctl_addr in 25: byte address requested.
- ioctl_din out 8: returned byte.
- ioctl_wait out 1: HPS must stall while high.
- pause_req out 1: request CPU halt.
- pause_ack in 1: CPU halted, RAM port free.
- ram_addr out ADDR_W: RAM read address.
- ram_rd out 1: RAM read strobe.
- ram_dout in 8: RAM read data, valid RAM_LAT cycles after ram_rd.
- busy out 1: session in progress (for LED or OSD).

Behaviour:
- Reset values of all outputs: ioctl_din=0, ioctl_wait=0, pause_req=0, ram_addr=0, ram_rd=0, busy=0. FSM goes to IDLE.
- Session active = ioctl_upload && ioctl_index==UPLOAD_INDEX, sampled every cycle.
- FSM states:
  - IDLE: outputs idle. On session active, go to PAUSE.
  - PAUSE: pause_req=1, ioctl_wait=1, busy=1. On pause_ack, go to READY.
  - READY: ioctl_wait=0. ioctl_rd with ioctl_addr<SIZE: ram_addr = BASE + ioctl_addr[ADDR_W-1:0] (modulo 2^ADDR_W), ram_rd=1 for one cycle, ioctl_wait=1, go to FETCH. ioctl_rd with ioctl_addr>=SIZE: ioctl_din=0x00 the next cycle, no RAM access, no wait.
  - FETCH: hold ioctl_wait=1 and count RAM_LAT cycles, then latch ram_dout into ioctl_din and go to PRESENT.
  - PRESENT: ioctl_wait=0 this cycle, go to READY.
- Latency: ioctl_rd to ioctl_wait low is RAM_LAT+1 cycles. ioctl_din holds its value until the next read.
- Session end (active falls, in any state other than IDLE): abort any fetch and discard its data. Go to RELEASE: pause_req=0, ioctl_wait=0, busy=0 for one cycle, then IDLE.
- pause_req is held high for the whole session. pause_ack dropping mid-session is ignored.
- ioctl_rd while ioctl_wait=1 is a protocol violation: ignored, no second RAM access.
- Reset mid-session: FSM goes to IDLE and pause_req drops in the same cycle.
- ioctl_rd outside a session has no effect.

Optional Feature:
- Macro: NVRAM_UPLOAD_CHECKSUM_EN.
- Defined:
  - A 16-bit running sum accumulates every RAM byte presented in the session; it clears on entry to PAUSE.
  - ioctl_addr==SIZE returns sum[7:0]; ioctl_addr==SIZE+1 returns sum[15:8].
  - Both return with zero wait. Addresses >SIZE+1 return 0x00.
- Undefined: all addresses >=SIZE return 0x00, and no accumulator is built.

Test Plan:
- Idle/index filter: ioctl_upload=1 with ioctl_index=0 -> pause_req, busy, and ioctl_wait all stay 0.
- Pause handshake: session starts, pause_ack held 0 for 20 cycles -> ioctl_wait=1 and pause_req=1 throughout. pause_ack=1 -> ioctl_wait=0 next cycle.
- Read path, RAM_LAT=2, BASE=0x300, RAM[0x305]=0xA5: ioctl_rd with addr 5 -> ram_addr=0x305, ram_rd pulse, ioctl_wait high for 3 cycles, then ioctl_din=0xA5.
- Out of range, SIZE=256: addr 0x100 -> ioctl_din=0x00, ioctl_wait never rises, ram_rd never pulses. With NVRAM_UPLOAD_CHECKSUM_EN and bytes 0..255 = i uploaded: addr 0x100 -> 0x80, addr 0x101 -> 0x7F.
- Abort: ioctl_upload drops during FETCH -> pause_req=0 within 1 cycle, ioctl_din unchanged, FSM in IDLE after 2 cycles.
- Reset during READY -> all outputs 0 on the next edge. A new session after that redoes the pause handshake.
